// File: rtl/fifo_access_arbiter_pkg.sv
// Shared types and defaults for the FIFO access arbiter.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package fifo_arb_pkg;

  // Arbiter FSM: one FIFO operation per grant, always separated by IDLE
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD      = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

  // Last completed operation, used to alternate contested grants
  typedef enum logic {
    OP_WR = 1'b0,
    OP_RD = 1'b1
  } op_t;

  localparam int DEF_DW    = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/fifo_access_arbiter_rr_pick.sv
// Round-robin selector: first requester at or after i_ptr (wrapping) wins.
// Latency: combinational.
// Backpressure: none; the caller decides whether to act on the pick.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_WR = 2,
  parameter int IW     = $clog2(NUM_WR)
) (
  input  logic [NUM_WR-1:0] i_req,
  input  logic [IW-1:0]     i_ptr,
  output logic [IW-1:0]     o_gnt_idx,
  output logic              o_gnt_vld
);

  logic [IW-1:0] w_idx;

  // Scan from the farthest offset down so the nearest requester to i_ptr overwrites last
  always_comb begin
    o_gnt_idx = '0;
    o_gnt_vld = 1'b0;
    w_idx     = '0;
    for (int k = NUM_WR - 1; k >= 0; k--) begin
      w_idx = IW'((int'(i_ptr) + k) % NUM_WR);
      if (i_req[w_idx]) begin
        o_gnt_idx = w_idx;
        o_gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Shares one single-port FIFO between NUM_WR producers and one consumer; optional stats under FIFO_ARB_STATS_EN.
// Latency: write ack 1 cycle after grant (1 per 2 cycles); read valid 2 cycles after fifo_rd_req (1 per 3 cycles).
// Backpressure: writes stall while fifo_full, reads stall while fifo_empty; flags sampled only in IDLE.
module fifo_access_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_WR = 2,
  parameter int DW     = DEF_DW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_WR-1:0]    wr_req,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic [NUM_WR-1:0]    wr_ack,
  input  logic                 rd_req,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_valid,
  output logic                 fifo_wr_en,
  output logic                 fifo_rd_req,
  output logic [DW-1:0]        fifo_wdata,
  input  logic [DW-1:0]        fifo_rdata,
  input  logic                 fifo_empty,
  input  logic                 fifo_full,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     stat_wr_cnt,
  output logic [CNT_W-1:0]     stat_rd_cnt
);

  localparam int IW = $clog2(NUM_WR);

  state_t            r_state;
  op_t               r_last_op;
  logic [IW-1:0]     r_rr_ptr;
  logic [IW-1:0]     r_gnt;
  logic [NUM_WR-1:0] r_wr_ack;
  logic [DW-1:0]     r_rd_data;
  logic              r_rd_valid;
  logic              r_fifo_wr_en;
  logic              r_fifo_rd_req;
  logic [DW-1:0]     r_fifo_wdata;

  logic [IW-1:0]     w_pick_idx;
  logic              w_pick_vld;
  logic              w_wr_cand;
  logic              w_rd_cand;
  logic              w_grant_wr;
  logic              w_grant_rd;
  logic [IW-1:0]     w_ptr_nxt;
  logic [DW-1:0]     w_wr_data [NUM_WR];

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_unpack
    assign w_wr_data[gi] = wr_data[gi*DW +: DW];
  end

  rr_pick #(
    .NUM_WR (NUM_WR),
    .IW     (IW)
  ) u_rr_pick (
    .i_req     (wr_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt_idx (w_pick_idx),
    .o_gnt_vld (w_pick_vld)
  );

  // Contested grants go to the op that did not run last
  assign w_wr_cand  = w_pick_vld & ~fifo_full;
  assign w_rd_cand  = rd_req & ~fifo_empty;
  assign w_grant_wr = w_wr_cand & (~w_rd_cand | (r_last_op == OP_RD));
  assign w_grant_rd = w_rd_cand & ~w_grant_wr;
  assign w_ptr_nxt  = (r_gnt == IW'(NUM_WR - 1)) ? '0 : r_gnt + IW'(1);

  // Arbiter FSM with registered FIFO strobes and producer/consumer handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last_op     <= OP_RD;
      r_rr_ptr      <= '0;
      r_gnt         <= '0;
      r_wr_ack      <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_fifo_wr_en  <= 1'b0;
      r_fifo_rd_req <= 1'b0;
      r_fifo_wdata  <= '0;
    end else begin
      r_wr_ack      <= '0;
      r_rd_valid    <= 1'b0;
      r_fifo_wr_en  <= 1'b0;
      r_fifo_rd_req <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_wr) begin
            r_state      <= WR;
            r_gnt        <= w_pick_idx;
            r_fifo_wr_en <= 1'b1;
            r_fifo_wdata <= w_wr_data[w_pick_idx];
            r_wr_ack     <= NUM_WR'(1) << w_pick_idx;
          end else if (w_grant_rd) begin
            r_state       <= RD;
            r_fifo_rd_req <= 1'b1;
          end
        end
        WR: begin
          r_rr_ptr  <= w_ptr_nxt;
          r_last_op <= OP_WR;
          r_state   <= IDLE;
        end
        RD: begin
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          r_rd_data  <= fifo_rdata;
          r_rd_valid <= 1'b1;
          r_last_op  <= OP_RD;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_ack      = r_wr_ack;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign fifo_wr_en  = r_fifo_wr_en;
  assign fifo_rd_req = r_fifo_rd_req;
  assign fifo_wdata  = r_fifo_wdata;

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_W-1:0] r_stat_wr_cnt;
  logic [CNT_W-1:0] r_stat_rd_cnt;

  // Saturating op counters; clear beats a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_wr_cnt <= '0;
      r_stat_rd_cnt <= '0;
    end else if (stat_clr) begin
      r_stat_wr_cnt <= '0;
      r_stat_rd_cnt <= '0;
    end else begin
      if ((|r_wr_ack) && (r_stat_wr_cnt != '1)) r_stat_wr_cnt <= r_stat_wr_cnt + CNT_W'(1);
      if (r_rd_valid && (r_stat_rd_cnt != '1))  r_stat_rd_cnt <= r_stat_rd_cnt + CNT_W'(1);
    end
  end

  assign stat_wr_cnt = r_stat_wr_cnt;
  assign stat_rd_cnt = r_stat_rd_cnt;
`else
  logic w_stat_clr_unused;
  assign w_stat_clr_unused = stat_clr;
  assign stat_wr_cnt       = '0;
  assign stat_rd_cnt       = '0;
`endif

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed bench for fifo_access_arbiter with a small behavioural FIFO behind it.
// Latency: n/a.
// Backpressure: full/empty come from the FIFO model, optionally forced.
module tb_fifo_access_arbiter;

`ifdef FIFO_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  wr_req;
  logic [15:0] wr_data;
  logic [1:0]  wr_ack;
  logic        rd_req;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        fifo_wr_en;
  logic        fifo_rd_req;
  logic [7:0]  fifo_wdata;
  logic [7:0]  fifo_rdata;
  logic        fifo_empty;
  logic        fifo_full;
  logic        stat_clr;
  logic [15:0] stat_wr_cnt;
  logic [15:0] stat_rd_cnt;

  int total = 0;
  int bad   = 0;

  fifo_access_arbiter #(.NUM_WR(2), .DW(8), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_rd_req (fifo_rd_req),
    .fifo_wdata  (fifo_wdata),
    .fifo_rdata  (fifo_rdata),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .stat_clr    (stat_clr),
    .stat_wr_cnt (stat_wr_cnt),
    .stat_rd_cnt (stat_rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8-deep FIFO model with registered read data
  logic [7:0] q[$];
  int         m_cnt = 0;
  logic       flush_req = 1'b0;
  logic       pre_vld = 1'b0;
  logic [7:0] pre_dat = 8'h00;
  logic       force_full = 1'b0;
  logic       force_empty = 1'b0;

  initial fifo_rdata = 8'h00;

  always @(posedge clk) begin
    if (flush_req) q.delete();
    if (pre_vld) q.push_back(pre_dat);
    if (fifo_rd_req && q.size() != 0) begin
      fifo_rdata <= q[0];
      void'(q.pop_front());
    end
    if (fifo_wr_en && q.size() < 8) q.push_back(fifo_wdata);
    m_cnt <= q.size();
  end

  assign fifo_full  = (m_cnt >= 8) || force_full;
  assign fifo_empty = (m_cnt == 0) || force_empty;

  // Write strobe and read strobe must never coincide
  logic both_seen = 1'b0;
  always @(negedge clk) begin
    assert (!(fifo_wr_en && fifo_rd_req)) else both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_req = 2'b00; wr_data = 16'h0000; rd_req = 1'b0;
    stat_clr = 1'b0; force_full = 1'b0; force_empty = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [7:0] v);
    pre_vld = 1'b1; pre_dat = v;
    tick();
    pre_vld = 1'b0;
  endtask

  task automatic read_one(input string tag, input logic [7:0] exp);
    tick(); chk({tag, "_rdreq"}, 32'(fifo_rd_req), 1);
    tick(); chk({tag, "_early"}, 32'(rd_valid), 0);
    tick(); chk({tag, "_vld"}, 32'(rd_valid), 1);
    chk({tag, "_dat"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int  n_rd;
    bit  ack_seen;
    bit  seen;

    // Reset state
    rst_n = 1'b0; wr_req = 2'b00; wr_data = 16'h0000; rd_req = 1'b0;
    stat_clr = 1'b0;
    tick(); tick();
    chk("rst_wr_ack", 32'(wr_ack), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_wr_en", 32'(fifo_wr_en), 0);
    chk("rst_rd_req", 32'(fifo_rd_req), 0);
    chk("rst_wdata", 32'(fifo_wdata), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_stat_wr", 32'(stat_wr_cnt), 0);
    rst_n = 1'b1;

    // Single write from producer 0
    wr_req = 2'b01; wr_data = 16'h005A;
    tick();
    chk("w1_wr_en", 32'(fifo_wr_en), 1);
    chk("w1_ack", 32'(wr_ack), 32'h1);
    chk("w1_wdata", 32'(fifo_wdata), 32'h5A);
    chk("w1_no_rd", 32'(fifo_rd_req), 0);
    wr_req = 2'b00;
    tick();
    chk("w1_wr_en_off", 32'(fifo_wr_en), 0);
    chk("w1_ack_off", 32'(wr_ack), 0);
    chk("w1_stat", 32'(stat_wr_cnt), sx(1));

    // Two producers contending: alternate 0,1,0,1 every 2 cycles
    do_reset();
    wr_req = 2'b11; wr_data = 16'hB2A1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_ack", 32'(wr_ack), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_wdata", 32'(fifo_wdata), (k % 2 == 0) ? 32'hA1 : 32'hB2);
      if (k == 3) wr_req = 2'b00;
      tick();
      chk("rr_gap", 32'(fifo_wr_en), 0);
    end
    rd_req = 1'b1;
    read_one("rb0", 8'hA1);
    read_one("rb1", 8'hB2);
    read_one("rb2", 8'hA1);
    read_one("rb3", 8'hB2);
    rd_req = 1'b0;
    tick();
    chk("stat_wr4", 32'(stat_wr_cnt), sx(4));
    chk("stat_rd4", 32'(stat_rd_cnt), sx(4));
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_clr_wr", 32'(stat_wr_cnt), 0);
    chk("stat_clr_rd", 32'(stat_rd_cnt), 0);

    // Concurrent read and write with one entry held: WR, RD, WR, RD
    preload(8'h77);
    wr_req = 2'b01; wr_data = 16'h0033; rd_req = 1'b1;
    tick();
    chk("mix_w0_en", 32'(fifo_wr_en), 1);
    chk("mix_w0_dat", 32'(fifo_wdata), 32'h33);
    chk("mix_w0_nord", 32'(fifo_rd_req), 0);
    wr_data = 16'h0044;
    tick();
    tick();
    chk("mix_r0_req", 32'(fifo_rd_req), 1);
    chk("mix_r0_nowr", 32'(fifo_wr_en), 0);
    tick();
    chk("mix_r0_early", 32'(rd_valid), 0);
    tick();
    chk("mix_r0_vld", 32'(rd_valid), 1);
    chk("mix_r0_dat", 32'(rd_data), 32'h77);
    tick();
    chk("mix_w1_ack", 32'(wr_ack), 32'h1);
    chk("mix_w1_dat", 32'(fifo_wdata), 32'h44);
    wr_req = 2'b00;
    tick();
    tick();
    chk("mix_r1_req", 32'(fifo_rd_req), 1);
    tick();
    tick();
    chk("mix_r1_vld", 32'(rd_valid), 1);
    chk("mix_r1_dat", 32'(rd_data), 32'h33);
    rd_req = 1'b0;

    // Full FIFO: writes stall, reads still served
    force_full = 1'b1; wr_req = 2'b11; wr_data = 16'h6655;
    ack_seen = 1'b0; n_rd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wr_ack != 2'b00 || fifo_wr_en) ack_seen = 1'b1;
      if (rd_valid) begin
        n_rd++;
        rd_req = 1'b0;
      end
      if (i == 4) rd_req = 1'b1;
    end
    chk("full_no_ack", 32'(ack_seen), 0);
    chk("full_rd_cnt", 32'(n_rd), 1);
    chk("full_rd_dat", 32'(rd_data), 32'h44);
    force_full = 1'b0;
    tick();
    chk("unfull_ack", 32'(wr_ack), 32'h2);
    chk("unfull_dat", 32'(fifo_wdata), 32'h66);
    wr_req = 2'b01;
    tick();
    tick();
    chk("unfull_ack2", 32'(wr_ack), 32'h1);
    chk("unfull_dat2", 32'(fifo_wdata), 32'h55);
    wr_req = 2'b00;

    // Empty FIFO: read stalls until a write lands
    tick();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    rd_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (fifo_rd_req || rd_valid) seen = 1'b1;
    end
    chk("empty_stall", 32'(seen), 0);
    wr_req = 2'b01; wr_data = 16'h003C;
    tick();
    chk("empty_w_ack", 32'(wr_ack), 32'h1);
    wr_req = 2'b00;
    tick();
    tick();
    chk("empty_r_req", 32'(fifo_rd_req), 1);
    tick();
    tick();
    chk("empty_r_vld", 32'(rd_valid), 1);
    chk("empty_r_dat", 32'(rd_data), 32'h3C);
    rd_req = 1'b0;

    // Reset during RD_WAIT after a write left ptr=1, last_op=WR
    wr_req = 2'b01; wr_data = 16'h005C;
    tick();
    chk("pre_rst_ack", 32'(wr_ack), 32'h1);
    wr_req = 2'b00;
    tick();
    rd_req = 1'b1;
    tick();
    chk("pre_rst_rdreq", 32'(fifo_rd_req), 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_wdata", 32'(fifo_wdata), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_rd_req", 32'(fifo_rd_req), 0);
    rd_req = 1'b0;
    tick();
    chk("arst_no_vld", 32'(rd_valid), 0);
    chk("arst_stat", 32'(stat_wr_cnt), 0);
    preload(8'hAB);
    rst_n = 1'b1;
    wr_req = 2'b11; wr_data = 16'hD2D1; rd_req = 1'b1;
    tick();
    chk("post_rst_wr_en", 32'(fifo_wr_en), 1);
    chk("post_rst_ack", 32'(wr_ack), 32'h1);
    chk("post_rst_dat", 32'(fifo_wdata), 32'hD1);
    chk("post_rst_nord", 32'(fifo_rd_req), 0);
    wr_req = 2'b00; rd_req = 1'b0;
    tick(); tick(); tick();

    chk("never_both", 32'(both_seen), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
